// File: rtl/message_scheduler_if.sv
// Block-in / schedule-word-out handshake bundle for the SHA-256 message scheduler.
// master drives blocks and w_ready; slave is the scheduler.
interface message_scheduler_if;
    logic [511:0] block_in;
    logic         block_valid;
    logic         block_ready;
    logic [31:0]  w_out;
    logic         w_valid;
    logic         w_ready;
    logic [5:0]   round;
    logic         last_round;
    logic         busy;

    modport master (
        output block_in, block_valid, w_ready,
        input  block_ready, w_out, w_valid, round, last_round, busy
    );

    modport slave (
        input  block_in, block_valid, w_ready,
        output block_ready, w_out, w_valid, round, last_round, busy
    );
endinterface

// File: rtl/message_scheduler.sv
// SHA-256 message schedule generator: one 512-bit block in, W0..W63 out.
// Macro MSG_SCHED_BACKPRESSURE_EN makes w_ready stall the schedule.
module message_scheduler (
    input  logic                      clk,
    input  logic                      rst,
    message_scheduler_if.slave        bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] win [16];
    logic [31:0] nxt;
    logic        xfer;
    logic [5:0]  round_q;

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef MSG_SCHED_BACKPRESSURE_EN
    assign xfer = bus.w_valid & bus.w_ready;
`else
    logic unused_ready;
    assign unused_ready = bus.w_ready;
    assign xfer = bus.w_valid;
`endif

    assign nxt = s1(win[14]) + win[9] + s0(win[1]) + win[0];

    assign bus.w_out = win[0];
    assign bus.round = round_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            round_q         <= '0;
            bus.block_ready <= 1'b1;
            bus.w_valid     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.last_round  <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.block_valid) begin
                        for (int i = 0; i < 16; i++)
                            win[i] <= bus.block_in[511 - 32*i -: 32];
                        round_q         <= '0;
                        state           <= RUN;
                        bus.block_ready <= 1'b0;
                        bus.w_valid     <= 1'b1;
                        bus.busy        <= 1'b1;
                        bus.last_round  <= 1'b0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                        win[15] <= nxt;
                        // Round 63 retires the block instead of wrapping.
                        if (round_q == 6'd63) begin
                            round_q         <= '0;
                            state           <= IDLE;
                            bus.block_ready <= 1'b1;
                            bus.w_valid     <= 1'b0;
                            bus.busy        <= 1'b0;
                            bus.last_round  <= 1'b0;
                        end else begin
                            round_q        <= round_q + 6'd1;
                            bus.last_round <= (round_q == 6'd62);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_message_scheduler.sv
// Randomised self-checking bench for message_scheduler against a
// full-array SHA-256 expansion model.
module tb_message_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    message_scheduler_if bus ();

    message_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: whole 64-word schedule computed at accept time
    logic [31:0] m_w [64];
    bit          m_run = 0;
    int          m_idx = 0;
    bit          cmp_en = 0;
    bit          abc_mode = 0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic expand(input logic [511:0] b);
        for (int t = 0; t < 16; t++) m_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            m_w[t] = ss1(m_w[t-2]) + m_w[t-7] + ss0(m_w[t-15]) + m_w[t-16];
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    bit model_xfer;
    always @(posedge clk) begin
`ifdef MSG_SCHED_BACKPRESSURE_EN
        model_xfer = bus.w_ready;
`else
        model_xfer = 1'b1;
`endif
        if (rst) begin
            m_run = 0;
            m_idx = 0;
        end else if (!m_run) begin
            if (bus.block_valid) begin
                expand(bus.block_in);
                m_run = 1;
                m_idx = 0;
            end
        end else if (model_xfer) begin
            if (m_idx == 63) begin
                m_run = 0;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("status", {bus.block_ready, bus.w_valid, bus.busy, bus.last_round},
                {!m_run, m_run, m_run, m_run && m_idx == 63});
            if (m_run) begin
                chk("w_out", bus.w_out, m_w[m_idx]);
                chk("round", bus.round, m_idx);
            end
            if (abc_mode && m_run) begin
                if (m_idx == 0)  chk("abc_w0",  bus.w_out, 32'h61626380);
                if (m_idx == 15) chk("abc_w15", bus.w_out, 32'h00000018);
                if (m_idx == 16) chk("abc_w16", bus.w_out, 32'h61626380);
                if (m_idx == 17) chk("abc_w17", bus.w_out, 32'h000F0000);
            end
        end
    end

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic send(input logic [511:0] b);
        @(negedge clk);
        bus.block_in    = b;
        bus.block_valid = 1'b1;
        @(negedge clk);
        bus.block_valid = 1'b0;
        bus.block_in    = rand_block();
    endtask

    task automatic drain(input bit rnd);
        int k = 0;
        while (bus.busy && k < 400) begin
            bus.w_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", k < 400, 1);
        bus.w_ready = 1'b1;
    endtask

    task automatic wait_round(input int r);
        int k = 0;
        while (!(m_run && m_idx == r) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wait_round_timeout", k < 200, 1);
    endtask

    logic [511:0] abc, blk_a, blk_b;
    logic [31:0]  hold_w;
    int           k, vcnt, gap;

    initial begin
        rst             = 1'b1;
        bus.block_valid = 1'b0;
        bus.block_in    = '0;
        bus.w_ready     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_w_out", bus.w_out, 0);
        chk("rst_round", bus.round, 0);
        chk("rst_flags", {bus.block_ready, bus.w_valid, bus.last_round, bus.busy},
            4'b1000);
        rst    = 1'b0;
        cmp_en = 1;

        // "abc" block
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        abc_mode = 1;
        send(abc);
        chk("model_w16", m_w[16], 32'h61626380);
        chk("model_w17", m_w[17], 32'h000F0000);
        vcnt = 0;
        k = 0;
        while (k < 200) begin
            if (bus.w_valid) vcnt++;
            if (bus.last_round) break;
            @(negedge clk);
            k++;
        end
        chk("abc_valid_cycles", vcnt, 64);
        @(negedge clk);
        chk("abc_ready_after", {bus.block_ready, bus.w_valid}, 2'b10);
        abc_mode = 0;

        // Stall for 5 cycles at round 20
        send(rand_block());
        wait_round(20);
        bus.w_ready = 1'b0;
        hold_w = bus.w_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
`ifdef MSG_SCHED_BACKPRESSURE_EN
            chk("stall_w_out", bus.w_out, hold_w);
            chk("stall_round", bus.round, 20);
`endif
        end
        bus.w_ready = 1'b1;
        drain(0);

        // Two blocks queued with block_valid held high
        blk_a = rand_block();
        blk_b = rand_block();
        @(negedge clk);
        bus.block_in    = blk_a;
        bus.block_valid = 1'b1;
        @(negedge clk);
        bus.block_in = blk_b;
        k = 0;
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        gap = 0;
        while (!bus.busy && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap", gap, 1);
        bus.block_valid = 1'b0;
        drain(0);

        // Reset mid-block at round 30
        send(rand_block());
        wait_round(30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flags", {bus.w_valid, bus.block_ready, bus.busy}, 3'b010);
        chk("midrst_round", bus.round, 0);
        repeat (2) @(negedge clk);
        chk("midrst_quiet", bus.w_valid, 0);
        send(rand_block());
        drain(0);

`ifndef MSG_SCHED_BACKPRESSURE_EN
        // w_ready ignored: 64 back-to-back words
        @(negedge clk);
        bus.w_ready = 1'b0;
        send(rand_block());
        vcnt = 0;
        while (bus.w_valid && vcnt < 100) begin
            chk("noready_round", bus.round, vcnt);
            vcnt++;
            @(negedge clk);
        end
        chk("noready_count", vcnt, 64);
        bus.w_ready = 1'b1;
`endif

        // Random blocks with random w_ready
        for (int b = 0; b < 300; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(rand_block());
            drain(1);
        end

        repeat (2) @(negedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
